// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the NOP word presented on empty IF/ID slots.
// No logic lives here; importers pick what they need.
package instr_fetch_unit_pkg;

  // addi x0, x0, 0 -- what the decoder sees when IF/ID is empty
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // just out of reset; ignores any stale response
    S_REQ  = 2'd1,  // presenting a fetch request
    S_WAIT = 2'd2,  // one good request outstanding
    S_DROP = 2'd3   // one wrong-path request outstanding, response gets discarded
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry IF/ID buffer: output register plus one skid slot, with push/pop/flush.
// Latency: a push is visible on the head one cycle later (registered head).
// Backpressure: pop only drains the head; skid_vld_o tells the fetcher to stop issuing.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_instr_i,
  input  logic            pop_i,
  output logic            head_vld_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o,
  output logic            skid_vld_o
);

  logic            out_v_q, out_v_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic            skid_v_q, skid_v_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            pop_eff;

  assign pop_eff = pop_i && out_v_q;

  // Next-state of both slots: flush wins, then pop/push ordering keeps entries in fetch order
  always_comb begin
    out_v_d      = out_v_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop_eff) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_pc_d    = skid_pc_q;
        out_instr_d = skid_instr_q;
        skid_v_d    = push_i;
        if (push_i) begin
          skid_pc_d    = push_pc_i;
          skid_instr_d = push_instr_i;
        end
      end else if (push_i) begin
        out_v_d     = 1'b1;
        out_pc_d    = push_pc_i;
        out_instr_d = push_instr_i;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (push_i) begin
      if (!out_v_q) begin
        out_v_d     = 1'b1;
        out_pc_d    = push_pc_i;
        out_instr_d = push_instr_i;
      end else begin
        skid_v_d     = 1'b1;
        skid_pc_d    = push_pc_i;
        skid_instr_d = push_instr_i;
      end
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q      <= 1'b0;
      out_pc_q     <= RESET_PC;
      out_instr_q  <= XLEN'(INST_NOP);
      skid_v_q     <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      out_v_q      <= out_v_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign head_vld_o   = out_v_q;
  assign head_pc_o    = out_pc_q;
  assign head_instr_o = out_v_q ? out_instr_q : XLEN'(INST_NOP);
  assign skid_vld_o   = skid_v_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem req/gnt/rvalid fetch, redirect handling, IF/ID output.
// Latency: gnt at T, rvalid at T+k -> if_valid_o at T+k+1.
// Backpressure: stall_i only holds the IF/ID head; issue stops when the skid slot is occupied.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;  // address of the request in flight
  logic [XLEN-1:0] redirect_tgt;
  logic            push;
  logic            consume;
  logic            skid_vld;

  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign consume      = if_valid_o && !stall_i;
  assign imem_addr_o  = pc_q;

  // Fetch FSM: issue, wait for the response, or discard a wrong-path response; redirect always reloads the PC
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req_o = !skid_vld;
        if (imem_req_o && imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = redirect_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          push    = !redirect_i;
          state_d = S_REQ;
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_i) pc_d = redirect_tgt;
  end

  // FSM and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buffer #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_pc_i    (req_pc_q),
    .push_instr_i (imem_rdata_i),
    .pop_i        (consume),
    .head_vld_o   (if_valid_o),
    .head_pc_o    (if_pc_o),
    .head_instr_o (if_instr_o),
    .skid_vld_o   (skid_vld)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, expected IF/ID entries queued up front,
// a monitor pops and compares on every consumed output; a memory model answers imem requests.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // memory model controls
  bit          gnt_en = 1'b0;
  int          lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_dat = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_dat = '0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gnt_en = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    ovr_en = 1'b0;
    lat = 1;
    exp_q.delete();
    tick(5);
    #2;
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_instr", if_instr_o, INST_NOP);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d entries never emitted, want 0", name, exp_q.size());
    end
  endtask

  // Memory: grant when enabled, answer after lat cycles; one-shot data override
  initial begin
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i = pend_dat;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_gnt_i = gnt_en;
      if (gnt_en && imem_req_o) begin
        pend = 1'b1;
        cnt = lat - 1;
        pend_dat = ovr_en ? ovr_dat : mem_word(imem_addr_o);
        ovr_en = 1'b0;
      end
    end
  end

  // Monitor: compare every consumed IF/ID entry against the scoreboard; empty slot must show NOP
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!if_valid_o) begin
        chk("nop_when_empty", if_instr_o, INST_NOP);
      end else if (!stall_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_pc", if_pc_o, e.pc);
        chk("out_instr", if_instr_o, e.instr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: streaming from reset, one word every two cycles
    do_reset();
    gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    #2;
    chk("t1_first_valid", {31'd0, if_valid_o}, 32'd1);
    chk("t1_first_pc", if_pc_o, 32'h0);
    tick(2);
    #2;
    chk("t1_second_pc", if_pc_o, 32'h4);
    drain("t1_drain");

    // 2: stall fills output + skid, issue stops, release drains in order
    do_reset();
    gnt_en = 1'b1;
    push_exp(32'h8); push_exp(32'hC); push_exp(32'h10); push_exp(32'h14);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8;
    stall_i = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    tick(6);
    #2;
    chk("t2_hold_valid", {31'd0, if_valid_o}, 32'd1);
    chk("t2_hold_pc", if_pc_o, 32'h8);
    chk("t2_req_off", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk);
    stall_i = 1'b0;
    drain("t2_drain");

    // 3: redirect while waiting, late response discarded
    do_reset();
    gnt_en = 1'b1;
    lat = 4;
    ovr_en = 1'b1;
    ovr_dat = 32'hDEAD_BEEF;
    push_exp(32'h100); push_exp(32'h104);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3_no_valid", {31'd0, if_valid_o}, 32'd0);
      if (i == 3) chk("t3_next_addr", {imem_addr_o[31:1], imem_req_o}, 32'h101);
      @(negedge clk);
    end
    drain("t3_drain");

    // 4: redirect in the same cycle as the grant at 0x20
    do_reset();
    gnt_en = 1'b1;
    lat = 2;
    push_exp(32'h40); push_exp(32'h44);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h20;
    @(negedge clk);
    redirect_pc_i = 32'h40;
    #2;
    chk("t4_req_addr", imem_addr_o, 32'h20);
    chk("t4_req_on", {31'd0, imem_req_o}, 32'd1);
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    chk("t4_drop_req", {31'd0, imem_req_o}, 32'd0);
    tick(2);
    #2;
    chk("t4_target_addr", imem_addr_o, 32'h40);
    chk("t4_target_req", {31'd0, imem_req_o}, 32'd1);
    drain("t4_drain");

    // 5: misaligned redirect target, redirect together with stall flushes
    do_reset();
    gnt_en = 1'b1;
    stall_i = 1'b1;
    push_exp(32'h200); push_exp(32'h204);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h203;
    #2;
    chk("t5_pre_valid", {31'd0, if_valid_o}, 32'd1);
    chk("t5_pre_pc", if_pc_o, 32'h0);
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    #2;
    chk("t5_flush_valid", {31'd0, if_valid_o}, 32'd0);
    chk("t5_flush_instr", if_instr_o, 32'h0000_0013);
    chk("t5_aligned_addr", imem_addr_o, 32'h200);
    drain("t5_drain");

    // 6: reset mid-wait, stale response lands while idle
    do_reset();
    gnt_en = 1'b1;
    lat = 3;
    ovr_en = 1'b1;
    ovr_dat = 32'hBAD0_BAD0;
    push_exp(32'h0); push_exp(32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("t6_rst_valid", {31'd0, if_valid_o}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    #2;
    chk("t6_idle_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk);
    #2;
    chk("t6_first_addr", imem_addr_o, 32'h0);
    chk("t6_first_req", {31'd0, imem_req_o}, 32'd1);
    drain("t6_drain");

    // 7: PC wraps from the top of the address space
    do_reset();
    gnt_en = 1'b1;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    drain("t7_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
